prometheus_fx3_mode_sched: RTL and testbench
============================================

# prometheus_fx3_mode_sched

Arbiter and sequencer that shares the single FX3 slave-FIFO GPIF bus between the stream-in (FPGA→FX3 write) engine and the stream-out (FX3→FPGA read) engine. It sits between the engines and the GPIF pad logic. It picks one engine per bus tenure using FIFO-flag eligibility and round-robin fairness, sets up the socket address, and asserts that engine's `mode_selected`. It muxes the granted engine's strobes onto the pads and enforces a turnaround gap before re-arbitrating.

## Interface
Parameters:
- `ADDR_SETUP`, 2: cycles the address is stable before `mode_selected` asserts (1..15).
- `TURNAROUND`, 3: idle cycles after a tenure before the next arbitration (0..15).
- `ACT_TIMEOUT`, 64: cycles a granted engine may stay inactive before the grant is revoked (1..255).
- `IN_ADDR`, 2'b00: socket address driven for a stream-in tenure.
- `OUT_ADDR`, 2'b11: socket address driven for a stream-out tenure.

Ports:
- `clk_100`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_stream_in_en`  in  1  stream-in engine requested by control register.
- `i_stream_out_en`  in  1  stream-out engine requested by control register.
- `i_gpif_wr_rdy_d`  in  1  registered FX3 "space available" flag for the write socket.
- `i_gpif_rd_rdy_d`  in  1  registered FX3 "data available" flag for the read socket.
- `i_stream_in_we_n`  in  1  stream-in engine write strobe.
- `i_stream_out_re_n`  in  1  stream-out engine read strobe.
- `i_stream_out_oe_n`  in  1  stream-out engine output-enable strobe.
- `o_stream_in_mode_selected`  out  1  start/hold permission to stream-in engine.
- `o_stream_out_mode_selected`  out  1  start/hold permission to stream-out engine.
- `o_gpif_addr`  out  2  socket address to pads.
- `o_gpif_we_n`  out  1  muxed write strobe.
- `o_gpif_re_n`  out  1  muxed read strobe.
- `o_gpif_oe_n`  out  1  muxed output enable.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_strobe_err`  out  1  one-cycle pulse when a non-owning engine drives any strobe low.

## Operation
- Eligibility:
  - `req_in = i_stream_in_en & i_gpif_wr_rdy_d`.
  - `req_out = i_stream_out_en & i_gpif_rd_rdy_d`.
- States and transitions:
  - IDLE: if any request is present, latch the owner and go to SETUP.
    - Only one requester: grant it.
    - Both: grant the one opposite to `last_owner` (reset value is OUT, so IN wins the first tie).
  - SETUP: drive the owner's address and count `ADDR_SETUP` cycles, then go to GRANT.
  - GRANT: assert the owner's `mode_selected`.
    - Set `seen_active` when any owner strobe is low.
    - Go to DRAIN when any of these holds:
      - (a) `seen_active` is set and all owner strobes are high. This completes the burst.
      - (b) The owner's `_en` is low.
      - (c) The inactivity counter reaches `ACT_TIMEOUT` while `seen_active` is 0.
  - DRAIN: `mode_selected` is low and the address is held.
    - Wait until all owner strobes are high. The engine runs out its own RE/OE delay tail.
    - Then count `TURNAROUND` cycles, update `last_owner`, and go to IDLE.
- Mux rules:
  - In SETUP, GRANT and DRAIN, pad strobes follow the owner's inputs combinationally. Non-owner strobes are forced high.
  - In IDLE, all pad strobes are high.
  - For an IN owner, `o_gpif_re_n` and `o_gpif_oe_n` are 1.
  - For an OUT owner, `o_gpif_we_n` is 1.
- `o_strobe_err`: a registered pulse, set when a non-owner strobe is low or when any strobe is low in IDLE.
- `o_gpif_addr` changes only on the IDLE→SETUP transition. It holds its value through IDLE.
- Counters saturate and never wrap. The inactivity counter clears on SETUP→GRANT.

## Timing
- Reset values:
  - state IDLE, `last_owner` OUT.
  - `o_gpif_addr` = `IN_ADDR`.
  - All `mode_selected` = 0, all pad strobes = 1.
  - `o_busy` = 0, `o_strobe_err` = 0.
- Request latency: a request sampled high in IDLE at edge N gives SETUP at N+1. `mode_selected` is high from edge N+1+`ADDR_SETUP`.
- `mode_selected` deasserts on the edge that enters DRAIN, one cycle after the terminating condition is sampled.
- Minimum gap between tenures: `TURNAROUND` cycles + 1 IDLE cycle. Request drop during SETUP: complete SETUP, enter GRANT, exit via (b) next cycle.
- Reset asserted mid-tenure: all outputs return to reset values asynchronously. Pad strobes go high even while the engine's strobes are low.
- Flag drop during GRANT is not a termination condition. The engine owns flag handling.

## Test plan
- Single IN request with `i_gpif_wr_rdy_d`=1 and defaults:
  - `o_gpif_addr`=00 at cycle 1.
  - `o_stream_in_mode_selected` high at cycle 3.
  - `we_n` pulsed low for 8 cycles and passed through.
  - DRAIN is followed by 3 idle cycles before `o_busy`=0.
- Both requests continuously asserted:
  - Grants alternate IN, OUT, IN, OUT.
  - The address alternates 00/11.
  - No tenure overlaps, and there is at least a 4-cycle gap between `mode_selected` pulses.
- OUT tenure whose `re_n` rises 1 cycle before `oe_n` (rising 3 cycles later): DRAIN holds address 11 until `oe_n` is high, then counts turnaround.
- Granted IN engine never strobes: `mode_selected` drops after 64 cycles, and the next request is served normally.
- Non-owner strobe:
  - Stream-out `re_n` driven low during an IN tenure: `o_gpif_re_n` stays 1.
  - `o_strobe_err` pulses 1 cycle later.
- `rst_n` pulsed low mid-GRANT: all outputs reset immediately. After release, the first tie is granted to IN.

Source files
------------

// File: rtl/prometheus_fx3_mode_sched.sv
// prometheus_fx3_mode_sched: shares the FX3 slave-FIFO GPIF bus between the
// stream-in and stream-out engines with setup, drain and turnaround phases.
module prometheus_fx3_mode_sched #(
    parameter int unsigned ADDR_SETUP  = 2,
    parameter int unsigned TURNAROUND  = 3,
    parameter int unsigned ACT_TIMEOUT = 64,
    parameter logic [1:0]  IN_ADDR     = 2'b00,
    parameter logic [1:0]  OUT_ADDR    = 2'b11
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       i_stream_in_en,
    input  logic       i_stream_out_en,
    input  logic       i_gpif_wr_rdy_d,
    input  logic       i_gpif_rd_rdy_d,
    input  logic       i_stream_in_we_n,
    input  logic       i_stream_out_re_n,
    input  logic       i_stream_out_oe_n,
    output logic       o_stream_in_mode_selected,
    output logic       o_stream_out_mode_selected,
    output logic [1:0] o_gpif_addr,
    output logic       o_gpif_we_n,
    output logic       o_gpif_re_n,
    output logic       o_gpif_oe_n,
    output logic       o_busy,
    output logic       o_strobe_err
);

    localparam logic [3:0] SETUP_LAST = 4'(ADDR_SETUP - 1);
    localparam logic [3:0] TA_LAST    = 4'(TURNAROUND);
    localparam logic [7:0] ACT_LAST   = 8'(ACT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_GRANT,
        S_DRAIN
    } state_t;

    state_t     state;
    logic       owner_out;
    logic       last_out;
    logic       seen_active;
    logic       viol_q;
    logic [3:0] cnt;
    logic [7:0] act_cnt;

    logic req_in;
    logic req_out;
    logic pick_out;
    logic in_own;
    logic out_own;
    logic own_low;
    logic own_en;
    logic grant_done;
    logic viol;

    assign req_in   = i_stream_in_en & i_gpif_wr_rdy_d;
    assign req_out  = i_stream_out_en & i_gpif_rd_rdy_d;
    // On a tie the engine that did not own the previous tenure wins.
    assign pick_out = (req_in & req_out) ? ~last_out : req_out;

    assign in_own  = (state != S_IDLE) & ~owner_out;
    assign out_own = (state != S_IDLE) & owner_out;

    assign own_low = owner_out ? (~i_stream_out_re_n | ~i_stream_out_oe_n)
                               : ~i_stream_in_we_n;
    assign own_en  = owner_out ? i_stream_out_en : i_stream_in_en;

    assign grant_done = (seen_active & ~own_low)
                      | ~own_en
                      | (~seen_active & (act_cnt == ACT_LAST));

    assign viol = (~in_own & ~i_stream_in_we_n)
                | (~out_own & (~i_stream_out_re_n | ~i_stream_out_oe_n));

    assign o_gpif_we_n = in_own  ? i_stream_in_we_n  : 1'b1;
    assign o_gpif_re_n = out_own ? i_stream_out_re_n : 1'b1;
    assign o_gpif_oe_n = out_own ? i_stream_out_oe_n : 1'b1;
    assign o_busy      = (state != S_IDLE);

    // Tenure sequencer: arbitrate, address setup, grant, drain/turnaround.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= S_IDLE;
            owner_out                  <= 1'b0;
            last_out                   <= 1'b1;
            seen_active                <= 1'b0;
            cnt                        <= 4'd0;
            act_cnt                    <= 8'd0;
            o_gpif_addr                <= IN_ADDR;
            o_stream_in_mode_selected  <= 1'b0;
            o_stream_out_mode_selected <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_in | req_out) begin
                        owner_out   <= pick_out;
                        o_gpif_addr <= pick_out ? OUT_ADDR : IN_ADDR;
                        cnt         <= 4'd0;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        act_cnt                    <= 8'd0;
                        seen_active                <= 1'b0;
                        o_stream_in_mode_selected  <= ~owner_out;
                        o_stream_out_mode_selected <= owner_out;
                        state                      <= S_GRANT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_GRANT: begin
                    seen_active <= seen_active | own_low;
                    if (act_cnt != ACT_LAST) begin
                        act_cnt <= act_cnt + 8'd1;
                    end
                    if (grant_done) begin
                        o_stream_in_mode_selected  <= 1'b0;
                        o_stream_out_mode_selected <= 1'b0;
                        cnt                        <= 4'd0;
                        state                      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (own_low) begin
                        cnt <= 4'd0;
                    end else if (cnt == TA_LAST) begin
                        last_out <= owner_out;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pulse once at the onset of any strobe driven by a non-owner.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            viol_q       <= 1'b0;
            o_strobe_err <= 1'b0;
        end else begin
            viol_q       <= viol;
            o_strobe_err <= viol & ~viol_q;
        end
    end

endmodule

// File: tb/tb_prometheus_fx3_mode_sched.sv
// tb_prometheus_fx3_mode_sched: randomized tenures checked against
// cycle timelines derived from the arbitration and sequencing rules.
module tb_prometheus_fx3_mode_sched;

    localparam int AS = 2;
    localparam int TA = 3;
    localparam int TO = 64;
    localparam logic [1:0] IN_A  = 2'b00;
    localparam logic [1:0] OUT_A = 2'b11;

    logic clk_100 = 1'b0;
    logic rst_n = 1'b1;
    logic en_in, en_out, wr_rdy, rd_rdy, we_d, re_d, oe_d;
    logic in_sel, out_sel, we_p, re_p, oe_p, busy, err;
    logic [1:0] addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [8:0] obs;
    bit exp_last = 1'b1;
    logic [1:0] exp_addr = IN_A;
    int last_hi = -1000;
    bit prev_sel = 1'b0;

    prometheus_fx3_mode_sched #(
        .ADDR_SETUP(AS), .TURNAROUND(TA), .ACT_TIMEOUT(TO),
        .IN_ADDR(IN_A), .OUT_ADDR(OUT_A)
    ) dut (
        .clk_100(clk_100),
        .rst_n(rst_n),
        .i_stream_in_en(en_in),
        .i_stream_out_en(en_out),
        .i_gpif_wr_rdy_d(wr_rdy),
        .i_gpif_rd_rdy_d(rd_rdy),
        .i_stream_in_we_n(we_d),
        .i_stream_out_re_n(re_d),
        .i_stream_out_oe_n(oe_d),
        .o_stream_in_mode_selected(in_sel),
        .o_stream_out_mode_selected(out_sel),
        .o_gpif_addr(addr),
        .o_gpif_we_n(we_p),
        .o_gpif_re_n(re_p),
        .o_gpif_oe_n(oe_p),
        .o_busy(busy),
        .o_strobe_err(err)
    );

    always #5 clk_100 = ~clk_100;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        en_in = 0; en_out = 0; wr_rdy = 0; rd_rdy = 0;
        we_d = 1; re_d = 1; oe_d = 1;
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk_100);
        obs = {in_sel, out_sel, addr, we_p, re_p, oe_p, busy, err};
        @(posedge clk_100);
        #1;
        cyc++;
    endtask

    // One full tenure starting in IDLE (k=0) and ending on its last busy
    // cycle. Expected outputs come from the tenure timeline:
    // grant at g=1+AS, drain entry dd, last busy cycle h+TA.
    task automatic run_tenure(input string nm, input bit ein, input bit eout,
                              input bit strobe, input int d, input int len,
                              input int tail, input int drop, input bit hold,
                              input int bad);
        bit own, act, badw, own_en, sel_now;
        int g, b, dd, h, db;
        logic [1:0] a;
        logic [8:0] ex;
        own = (ein && eout) ? !exp_last : eout;
        g = 1 + AS;
        b = g + d + len - 1 + (own ? tail : 0);
        dd = strobe ? b + 2 : g + TO;
        if (drop >= 0) begin
            db = ((drop > g) ? drop : g) + 1;
            if (db < dd) dd = db;
        end
        h = (strobe && (b + 1 > dd)) ? b + 1 : dd;
        a = own ? OUT_A : IN_A;
        for (int k = 0; k <= h + TA; k++) begin
            act = strobe && k >= g + d && k <= g + d + len - 1;
            badw = bad >= 0 && (k == bad || k == bad + 1);
            own_en = (drop >= 0) ? (k < drop) : (hold || k < dd);
            en_in = own ? ein : own_en;
            en_out = own ? own_en : eout;
            wr_rdy = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rd_rdy = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            we_d = !((!own && act) || (own && badw));
            re_d = !((own && act) || (!own && badw));
            oe_d = !(own && strobe && k >= g + d && k <= b);
            tick();
            ex[8] = !own && k >= g && k < dd;
            ex[7] = own && k >= g && k < dd;
            ex[6:5] = (k >= 1) ? a : exp_addr;
            ex[4] = (k >= 1 && !own) ? we_d : 1'b1;
            ex[3] = (k >= 1 && own) ? re_d : 1'b1;
            ex[2] = (k >= 1 && own) ? oe_d : 1'b1;
            ex[1] = (k >= 1);
            ex[0] = (bad >= 0 && k == bad + 1);
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL %s k=%0d sel/sel/addr/we/re/oe/busy/err got %b want %b",
                         nm, k, obs, ex);
            end
            sel_now = obs[8] | obs[7];
            if (sel_now && !prev_sel && last_hi >= 0) begin
                checks++;
                if (cyc - 1 - last_hi - 1 < 4) begin
                    failures++;
                    $display("FAIL %s grant_gap got %0d want >=4",
                             nm, cyc - 1 - last_hi - 1);
                end
            end
            if (sel_now) last_hi = cyc - 1;
            prev_sel = sel_now;
        end
        exp_last = own;
        exp_addr = a;
    endtask

    task automatic test_reset();
        logic [8:0] ex;
        idle_inputs();
        #2 rst_n = 0;
        #2;
        ex = {1'b0, 1'b0, IN_A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        obs = {in_sel, out_sel, addr, we_p, re_p, oe_p, busy, err};
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL reset_values got %b want %b", obs, ex);
        end
        repeat (2) @(posedge clk_100);
        #1 rst_n = 1;
        tick();
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL reset_idle got %b want %b", obs, ex);
        end
    endtask

    task automatic test_single_in();
        run_tenure("single_in8", 1, 0, 1, 0, 8, 0, -1, 0, -1);
        for (int i = 0; i < 2; i++)
            run_tenure("single_in", 1, 0, 1, $urandom_range(0, 3),
                       $urandom_range(1, 12), 0, -1, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_tenure("back_to_back", 1, 1, 1, $urandom_range(0, 3),
                       $urandom_range(1, 10), $urandom_range(0, 2), -1, 1, -1);
    endtask

    task automatic test_drain_tail();
        run_tenure("drain_tail3", 0, 1, 1, 1, 4, 3, 1 + AS + 5, 0, -1);
        run_tenure("drain_tail1", 0, 1, 1, 1, 4, 1, 1 + AS + 5, 0, -1);
    endtask

    task automatic test_timeout();
        run_tenure("timeout", 1, 0, 0, 0, 1, 0, -1, 0, -1);
        run_tenure("after_timeout", 1, 0, 1, 1, 5, 0, -1, 0, -1);
    endtask

    task automatic test_early_drop();
        run_tenure("drop_in_setup", 1, 0, 0, 0, 1, 0, 1, 0, -1);
        run_tenure("drop_out_setup", 0, 1, 0, 0, 1, 0, 2, 0, -1);
    endtask

    task automatic test_strobe_err();
        logic [8:0] ex;
        run_tenure("nonowner_in", 1, 0, 1, 4, 3, 0, -1, 0, 1 + AS + 1);
        run_tenure("nonowner_out", 0, 1, 1, 4, 3, 0, -1, 0, 1 + AS + 1);
        idle_inputs();
        we_d = 0;
        tick();
        we_d = 1;
        for (int k = 0; k < 3; k++) begin
            ex = {1'b0, 1'b0, exp_addr, 1'b1, 1'b1, 1'b1, 1'b0, 1'(k == 1)};
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL idle_strobe k=%0d got %b want %b", k, obs, ex);
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_random();
        int r, drop, bad;
        bit strobe;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(1, 3);
            strobe = ($urandom_range(0, 3) != 0);
            if (strobe)
                drop = ($urandom_range(0, 2) == 0) ?
                       $urandom_range(1, 1 + AS + 8) : -1;
            else
                drop = $urandom_range(1, 1 + AS + 6);
            bad = ($urandom_range(0, 3) == 0) ?
                  1 + AS + $urandom_range(0, 2) : -1;
            run_tenure("random", r[0], r[1], strobe, $urandom_range(0, 3),
                       $urandom_range(1, 10), $urandom_range(0, 3), drop,
                       1'($urandom_range(0, 1)), bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] ex;
        idle_inputs();
        en_out = 1;
        rd_rdy = 1;
        for (int k = 0; k <= 1 + AS + 1; k++) begin
            if (k == 1 + AS + 1) begin
                re_d = 0;
                oe_d = 0;
            end
            tick();
        end
        ex = {1'b0, 1'b1, OUT_A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL mid_grant got %b want %b", obs, ex);
        end
        #2 rst_n = 0;
        #1;
        obs = {in_sel, out_sel, addr, we_p, re_p, oe_p, busy, err};
        ex = {1'b0, 1'b0, IN_A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL async_reset got %b want %b", obs, ex);
        end
        idle_inputs();
        @(posedge clk_100);
        #1 rst_n = 1;
        exp_last = 1'b1;
        exp_addr = IN_A;
        prev_sel = 1'b0;
        run_tenure("tie_after_reset", 1, 1, 1, 0, 3, 0, -1, 0, -1);
        run_tenure("second_after_reset", 1, 1, 1, 1, 2, 1, -1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_single_in();
        test_back_to_back();
        test_drain_tail();
        test_timeout();
        test_early_drop();
        test_strobe_err();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
